stack_ctrl: RTL and testbench

Sequencer and configuration front end for the stacking combiner, the logistic second-stage block. It collects one 2-bit prediction from each of the three base learners into double-buffered slots. It owns the combiner's weight, bias and threshold registers and launches one combine per complete sample. It then waits for the combiner's result, with a timeout, and re-presents each result as a single-cycle valid with a sample count.

---
 rtl/stack_ctrl_if.sv | 50 +++++
 rtl/stack_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Bundle between the stacking-combiner sequencer and its environment:
// base-learner predictions, config port, combiner handshake and result stream.
interface stack_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             p1_valid;
    logic             p2_valid;
    logic             p3_valid;
    logic [1:0]       p1_pred;
    logic [1:0]       p2_pred;
    logic [1:0]       p3_pred;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [9:0]       cfg_wdata;
    logic             cfg_err;
    logic             comb_rst_n;
    logic             comb_ready;
    logic [1:0]       comb_pred1;
    logic [1:0]       comb_pred2;
    logic [1:0]       comb_pred3;
    logic [9:0]       weight1;
    logic [9:0]       weight2;
    logic [9:0]       weight3;
    logic [9:0]       bias;
    logic [9:0]       thred;
    logic             comb_done;
    logic [1:0]       comb_predict;
    logic             result_valid;
    logic [1:0]       result;
    logic [CNT_W-1:0] sample_cnt;
    logic             busy;
    logic             timeout_err;
    logic             overrun;

    modport slave (
        input  p1_valid, p2_valid, p3_valid, p1_pred, p2_pred, p3_pred,
        input  cfg_we, cfg_addr, cfg_wdata, comb_done, comb_predict,
        output cfg_err, comb_rst_n, comb_ready, comb_pred1, comb_pred2, comb_pred3,
        output weight1, weight2, weight3, bias, thred,
        output result_valid, result, sample_cnt, busy, timeout_err, overrun
    );

    modport master (
        output p1_valid, p2_valid, p3_valid, p1_pred, p2_pred, p3_pred,
        output cfg_we, cfg_addr, cfg_wdata, comb_done, comb_predict,
        input  cfg_err, comb_rst_n, comb_ready, comb_pred1, comb_pred2, comb_pred3,
        input  weight1, weight2, weight3, bias, thred,
        input  result_valid, result, sample_cnt, busy, timeout_err, overrun
    );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencer for the stacking combiner: gathers three base-learner predictions,
// owns combiner config, launches one combine per sample and reports results.
module stack_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    stack_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       flag_q, flag_d;
    logic [2:0][1:0]  slot_q, slot_d;
    logic [2:0][1:0]  comb_pred_q;
    logic [9:0]       weight1_q, weight2_q, weight3_q, bias_q, thred_q;
    logic             cfg_err_q, comb_rst_n_q, comb_ready_q;
    logic             result_valid_q, busy_q, timeout_err_q, overrun_q, overrun_d;
    logic [1:0]       result_q;
    logic [CNT_W-1:0] sample_cnt_q;

    logic [2:0]       valid_s;
    logic [2:0][1:0]  pred_s;
    logic             launch_s;
    logic             cfg_ok_s;

    // Slot fill and overrun detection; a launch hands the slots over and restarts the fill.
    always_comb begin
        valid_s  = {bus.p3_valid, bus.p2_valid, bus.p1_valid};
        pred_s   = {bus.p3_pred, bus.p2_pred, bus.p1_pred};
        launch_s = (state_q == ST_IDLE) && (&flag_q);
        cfg_ok_s = bus.cfg_we && (state_q == ST_IDLE) && (bus.cfg_addr <= 3'd4);
        if (launch_s) begin
            flag_d    = valid_s;
            overrun_d = 1'b0;
        end else begin
            flag_d    = flag_q | valid_s;
            overrun_d = |(valid_s & flag_q);
        end
        for (int i = 0; i < 3; i++) begin
            if (valid_s[i]) begin
                slot_d[i] = pred_s[i];
            end else begin
                slot_d[i] = slot_q[i];
            end
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            flag_q         <= 3'b000;
            slot_q         <= '0;
            comb_pred_q    <= '0;
            weight1_q      <= 10'd0;
            weight2_q      <= 10'd0;
            weight3_q      <= 10'd0;
            bias_q         <= 10'd0;
            thred_q        <= 10'd0;
            cfg_err_q      <= 1'b0;
            comb_rst_n_q   <= 1'b0;
            comb_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 2'b00;
            sample_cnt_q   <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            flag_q         <= flag_d;
            slot_q         <= slot_d;
            overrun_q      <= overrun_d;
            cfg_err_q      <= bus.cfg_we && !cfg_ok_s;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            comb_rst_n_q   <= 1'b1;
            if (cfg_ok_s) begin
                case (bus.cfg_addr)
                    3'd0:    weight1_q <= bus.cfg_wdata;
                    3'd1:    weight2_q <= bus.cfg_wdata;
                    3'd2:    weight3_q <= bus.cfg_wdata;
                    3'd3:    bias_q    <= bus.cfg_wdata;
                    3'd4:    thred_q   <= bus.cfg_wdata;
                    default: thred_q   <= thred_q;
                endcase
            end
            case (state_q)
                ST_IDLE: begin
                    comb_ready_q <= 1'b0;
                    if (launch_s) begin
                        comb_pred_q  <= slot_q;
                        comb_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_CLR;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_CLR: begin
                    comb_ready_q <= 1'b1;
                    cnt_q        <= '0;
                    busy_q       <= 1'b1;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.comb_done) begin
                        result_q       <= bus.comb_predict;
                        result_valid_q <= 1'b1;
                        sample_cnt_q   <= sample_cnt_q + CNT_W'(1);
                        comb_ready_q   <= 1'b0;
                        state_q        <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_err_q <= 1'b1;
                        comb_ready_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    comb_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_err      = cfg_err_q;
    assign bus.comb_rst_n   = comb_rst_n_q;
    assign bus.comb_ready   = comb_ready_q;
    assign bus.comb_pred1   = comb_pred_q[0];
    assign bus.comb_pred2   = comb_pred_q[1];
    assign bus.comb_pred3   = comb_pred_q[2];
    assign bus.weight1      = weight1_q;
    assign bus.weight2      = weight2_q;
    assign bus.weight3      = weight3_q;
    assign bus.bias         = bias_q;
    assign bus.thred        = thred_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.sample_cnt   = sample_cnt_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with a behavioural combiner stub and a
// result scoreboard.
module tb_stack_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_ctrl_if #(.CNT_W(CNT_W)) bus ();
    stack_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0, failures = 0, rv_count = 0, exp_cnt = 0;
    int cw1 = 0, cw2 = 0, cw3 = 0, cb = 0, ct = 0;
    logic [1:0] sb[$];
    bit         stub_en = 1'b1;
    logic       stub_done = 1'b0;
    logic [1:0] stub_pr = 2'b00;
    int         stub_lat = 0;

    function automatic int pv(input logic [1:0] p);
        return (p == 2'b01) ? 1 : -1;
    endfunction

    function automatic logic [1:0] model(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        int s;
        s = cw1 * pv(a) + cw2 * pv(b) + cw3 * pv(c) + cb;
        return (s >= ct) ? 2'b01 : 2'b11;
    endfunction

    // Combiner stub: sticky done a few cycles after ready, cleared by comb_rst_n.
    function automatic logic [1:0] stub_calc();
        int s;
        s = int'($signed(bus.weight1)) * int'($signed(bus.comb_pred1))
          + int'($signed(bus.weight2)) * int'($signed(bus.comb_pred2))
          + int'($signed(bus.weight3)) * int'($signed(bus.comb_pred3))
          + int'($signed(bus.bias));
        return (s >= int'($signed(bus.thred))) ? 2'b01 : 2'b11;
    endfunction

    always @(posedge clk) begin
        if (bus.comb_rst_n !== 1'b1) begin
            stub_done <= 1'b0;
            stub_lat  <= 0;
        end else if (bus.comb_ready === 1'b1 && stub_en && !stub_done) begin
            if (stub_lat == 3) begin
                stub_done <= 1'b1;
                stub_pr   <= stub_calc();
            end else begin
                stub_lat <= stub_lat + 1;
            end
        end
    end
    assign bus.comb_done    = stub_done;
    assign bus.comb_predict = stub_pr;

    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            rv_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_result got=%b want=no result", bus.result);
            end else begin
                logic [1:0] e;
                e = sb.pop_front();
                if (bus.result !== e) begin
                    failures++;
                    $display("FAIL sb_result got=%b want=%b", bus.result, e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input int value, input bit expect_ok);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = 10'(value);
        tick();
        bus.cfg_we = 1'b0;
        if (expect_ok) begin
            case (a)
                3'd0:    cw1 = value;
                3'd1:    cw2 = value;
                3'd2:    cw3 = value;
                3'd3:    cb  = value;
                default: ct  = value;
            endcase
        end
        checks++;
        if (bus.cfg_err !== !expect_ok) begin
            failures++;
            $display("FAIL cfg_err addr=%0d got=%b want=%b", a, bus.cfg_err, !expect_ok);
        end
    endtask

    task automatic drive_pred(input int n, input logic [1:0] p);
        case (n)
            1:       begin bus.p1_valid = 1'b1; bus.p1_pred = p; end
            2:       begin bus.p2_valid = 1'b1; bus.p2_pred = p; end
            default: begin bus.p3_valid = 1'b1; bus.p3_pred = p; end
        endcase
        tick();
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        bus.p3_valid = 1'b0;
    endtask

    task automatic wait_rv(input int budget, input string name);
        int k = 0;
        while (bus.result_valid !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (bus.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_result_timeout got=no result_valid want=result_valid within %0d cycles", name, budget);
        end else begin
            exp_cnt++;
            checks++;
            if (bus.sample_cnt !== CNT_W'(exp_cnt)) begin
                failures++;
                $display("FAIL %s_sample_cnt got=%0d want=%0d", name, bus.sample_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0; bus.p3_valid = 1'b0;
        bus.p1_pred = 2'b00; bus.p2_pred = 2'b00; bus.p3_pred = 2'b00;
        bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 10'd0;
        rst = 1'b1;
        tick(3);
        checks++;
        if (bus.comb_rst_n !== 1'b0 || bus.busy !== 1'b0 || bus.comb_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=rst_n%b busy%b ready%b want=rst_n0 busy0 ready0",
                     bus.comb_rst_n, bus.busy, bus.comb_ready);
        end
        checks++;
        if (bus.result_valid !== 1'b0 || bus.sample_cnt !== '0 || bus.weight1 !== 10'd0
            || bus.thred !== 10'd0 || bus.comb_pred1 !== 2'b00 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got=rv%b cnt%0d w1=%0d th=%0d cp1=%b ovr%b want=all zero",
                     bus.result_valid, bus.sample_cnt, bus.weight1, bus.thred, bus.comb_pred1, bus.overrun);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.comb_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rst_n got=%b want=1", bus.comb_rst_n);
        end
    endtask

    task automatic test_basic();
        cfg_write(3'd0, 5, 1'b1);
        cfg_write(3'd1, 3, 1'b1);
        cfg_write(3'd2, -2, 1'b1);
        cfg_write(3'd3, 1, 1'b1);
        cfg_write(3'd4, 0, 1'b1);
        checks++;
        if (bus.weight1 !== 10'd5 || bus.weight3 !== 10'h3FE || bus.bias !== 10'd1) begin
            failures++;
            $display("FAIL basic_cfg got=w1 %h w3 %h b %h want=w1 005 w3 3fe b 001",
                     bus.weight1, bus.weight3, bus.bias);
        end
        sb.push_back(2'b01);
        drive_pred(1, 2'b01);
        drive_pred(2, 2'b01);
        drive_pred(3, 2'b11);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_at_E got=%b want=0", bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.comb_rst_n !== 1'b0 || bus.comb_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_E1 got=busy%b rst_n%b ready%b want=busy1 rst_n0 ready0",
                     bus.busy, bus.comb_rst_n, bus.comb_ready);
        end
        tick();
        checks++;
        if (bus.comb_ready !== 1'b1 || bus.comb_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL basic_E2 got=ready%b rst_n%b want=ready1 rst_n1", bus.comb_ready, bus.comb_rst_n);
        end
        checks++;
        if (bus.comb_pred1 !== 2'b01 || bus.comb_pred2 !== 2'b01 || bus.comb_pred3 !== 2'b11) begin
            failures++;
            $display("FAIL basic_comb_pred got=%b/%b/%b want=01/01/11",
                     bus.comb_pred1, bus.comb_pred2, bus.comb_pred3);
        end
        wait_rv(40, "basic");
        tick();
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_rv_pulse got=rv%b busy%b want=rv0 busy0", bus.result_valid, bus.busy);
        end
    endtask

    task automatic test_all_neg_cfg_err();
        sb.push_back(model(2'b11, 2'b11, 2'b11));
        drive_pred(1, 2'b11);
        drive_pred(2, 2'b11);
        drive_pred(3, 2'b11);
        tick();
        cfg_write(3'd0, 7, 1'b0);
        checks++;
        if (bus.weight1 !== 10'd5) begin
            failures++;
            $display("FAIL busy_write_dropped got=%0d want=5", bus.weight1);
        end
        wait_rv(40, "allneg");
        tick(2);
        cfg_write(3'd6, 9, 1'b0);
        tick();
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_pulse got=%b want=0", bus.cfg_err);
        end
    endtask

    task automatic test_overrun();
        sb.push_back(model(2'b11, 2'b01, 2'b01));
        drive_pred(1, 2'b01);
        drive_pred(1, 2'b11);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pulse got=%b want=1", bus.overrun);
        end
        drive_pred(2, 2'b01);
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b want=0", bus.overrun);
        end
        drive_pred(3, 2'b01);
        tick();
        checks++;
        if (bus.comb_pred1 !== 2'b11) begin
            failures++;
            $display("FAIL overrun_comb_pred1 got=%b want=11", bus.comb_pred1);
        end
        wait_rv(40, "overrun");
        tick(2);
    endtask

    task automatic test_timeout();
        int k = 0;
        int rv0;
        rv0 = rv_count;
        stub_en = 1'b0;
        drive_pred(1, 2'b01);
        drive_pred(2, 2'b11);
        drive_pred(3, 2'b01);
        tick(2);
        while (bus.timeout_err !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (k != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d want=%0d", k, TIMEOUT);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.comb_ready !== 1'b0 || bus.sample_cnt !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL timeout_state got=busy%b ready%b cnt%0d want=busy0 ready0 cnt%0d",
                     bus.busy, bus.comb_ready, bus.sample_cnt, exp_cnt);
        end
        tick();
        checks++;
        if (bus.timeout_err !== 1'b0 || rv_count != rv0) begin
            failures++;
            $display("FAIL timeout_after got=terr%b rv%0d want=terr0 rv%0d", bus.timeout_err, rv_count, rv0);
        end
        stub_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        sb.push_back(model(2'b01, 2'b01, 2'b01));
        drive_pred(1, 2'b01);
        drive_pred(2, 2'b01);
        drive_pred(3, 2'b01);
        sb.push_back(model(2'b11, 2'b11, 2'b01));
        drive_pred(1, 2'b11);
        checks++;
        if (bus.overrun !== 1'b0 || bus.busy !== 1'b1 || bus.comb_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL b2b_launch_edge got=ovr%b busy%b rst_n%b want=ovr0 busy1 rst_n0",
                     bus.overrun, bus.busy, bus.comb_rst_n);
        end
        drive_pred(2, 2'b11);
        drive_pred(3, 2'b01);
        wait_rv(40, "b2b_first");
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.comb_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle got=busy%b rst_n%b want=busy0 rst_n1", bus.busy, bus.comb_rst_n);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.comb_rst_n !== 1'b0 || bus.comb_pred1 !== 2'b11) begin
            failures++;
            $display("FAIL b2b_relaunch got=busy%b rst_n%b cp1=%b want=busy1 rst_n0 cp1=11",
                     bus.busy, bus.comb_rst_n, bus.comb_pred1);
        end
        tick();
        checks++;
        if (bus.comb_rst_n !== 1'b1 || bus.comb_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wait got=rst_n%b ready%b want=rst_n1 ready1", bus.comb_rst_n, bus.comb_ready);
        end
        wait_rv(40, "b2b_second");
        tick(2);
    endtask

    task automatic test_reset_mid();
        int rv0;
        sb.push_back(model(2'b01, 2'b01, 2'b11));
        drive_pred(1, 2'b01);
        drive_pred(2, 2'b01);
        drive_pred(3, 2'b11);
        tick();
        drive_pred(1, 2'b01);
        rst = 1'b1;
        tick();
        checks++;
        if (bus.comb_rst_n !== 1'b0 || bus.busy !== 1'b0 || bus.comb_ready !== 1'b0
            || bus.result_valid !== 1'b0 || bus.sample_cnt !== '0 || bus.weight1 !== 10'd0
            || bus.comb_pred1 !== 2'b00) begin
            failures++;
            $display("FAIL midreset_outputs got=rst_n%b busy%b ready%b rv%b cnt%0d w1=%0d cp1=%b want=0 all",
                     bus.comb_rst_n, bus.busy, bus.comb_ready, bus.result_valid, bus.sample_cnt,
                     bus.weight1, bus.comb_pred1);
        end
        sb.delete();
        exp_cnt = 0;
        cw1 = 0; cw2 = 0; cw3 = 0; cb = 0; ct = 0;
        rst = 1'b0;
        rv0 = rv_count;
        tick(6);
        checks++;
        if (rv_count != rv0) begin
            failures++;
            $display("FAIL midreset_no_result got=%0d want=%0d", rv_count - rv0, 0);
        end
        cfg_write(3'd0, 5, 1'b1);
        cfg_write(3'd1, 3, 1'b1);
        cfg_write(3'd2, -2, 1'b1);
        cfg_write(3'd3, 1, 1'b1);
        drive_pred(2, 2'b11);
        drive_pred(3, 2'b11);
        tick(2);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_flags_cleared got=busy%b want=busy0", bus.busy);
        end
        sb.push_back(model(2'b01, 2'b11, 2'b11));
        drive_pred(1, 2'b01);
        wait_rv(40, "midreset_recover");
        tick(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_neg_cfg_err();
        test_overrun();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
